// File: rtl/axilite2wbm_pkg.sv
// axilite2wbm shared definitions.
// FSM encoding and AXI response codes.
package axilite2wbm_pkg;

  localparam int DW = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_STB,
    ST_WB_WAIT,
    ST_B_RESP,
    ST_R_RESP
  } state_e;

endpackage

// File: rtl/axilite2wbm.sv
// AXI4-Lite slave to pipelined Wishbone master bridge.
// One transaction in flight; WB err or timeout answers SLVERR.
module axilite2wbm
  import axilite2wbm_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGTIMEOUT        = 10
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_axi_awvalid,
  output logic                        o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr,
  input  logic [2:0]                  i_axi_awprot,
  input  logic                        i_axi_wvalid,
  output logic                        o_axi_wready,
  input  logic [DW-1:0]               i_axi_wdata,
  input  logic [DW/8-1:0]             i_axi_wstrb,
  output logic                        o_axi_bvalid,
  input  logic                        i_axi_bready,
  output logic [1:0]                  o_axi_bresp,
  input  logic                        i_axi_arvalid,
  output logic                        o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
  input  logic [2:0]                  i_axi_arprot,
  output logic                        o_axi_rvalid,
  input  logic                        i_axi_rready,
  output logic [DW-1:0]               o_axi_rdata,
  output logic [1:0]                  o_axi_rresp,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [C_AXI_ADDR_WIDTH-3:0] o_wb_addr,
  output logic [DW-1:0]               o_wb_data,
  output logic [DW/8-1:0]             o_wb_sel,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  input  logic [DW-1:0]               i_wb_data
);

  localparam int AW = C_AXI_ADDR_WIDTH - 2;
  localparam int TW = (LGTIMEOUT > 0) ? LGTIMEOUT : 1;
  localparam bit TO_EN = (LGTIMEOUT > 0);
  // Last count value before the timeout fires.
  localparam logic [TW-1:0] TLAST =
    TW'((64'd1 << TW) - 64'd2);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        resp_q, resp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              lww_q, lww_d;

  logic wr_pend;
  logic wb_hit;
  logic wb_to;

  // Protection bits and byte-lane address bits carry no meaning on WB.
  logic unused_ok;
  assign unused_ok = ^{i_axi_awprot, i_axi_arprot,
                       i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  assign wr_pend = i_axi_awvalid && i_axi_wvalid;

  // Next-state, handshake and WB/AXI output computation.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sel_d    = sel_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    lww_d    = lww_q;
    o_axi_awready = 1'b0;
    o_axi_wready  = 1'b0;
    o_axi_arready = 1'b0;
    wb_hit = 1'b0;
    wb_to  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!i_reset) begin
          o_axi_arready = !wr_pend || lww_q;
          o_axi_awready = wr_pend &&
            !(i_axi_arvalid && o_axi_arready);
          o_axi_wready  = o_axi_awready;
          if (o_axi_awready) begin
            addr_d  = i_axi_awaddr[AW+1:2];
            data_d  = i_axi_wdata;
            sel_d   = i_axi_wstrb;
            we_d    = 1'b1;
            lww_d   = 1'b1;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WB_STB;
          end else if (i_axi_arvalid) begin
            addr_d  = i_axi_araddr[AW+1:2];
            sel_d   = '1;
            we_d    = 1'b0;
            lww_d   = 1'b0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WB_STB;
          end
        end
      end
      ST_WB_STB, ST_WB_WAIT: begin
        if (TO_EN) cnt_d = cnt_q + 1'b1;
        if (state_q == ST_WB_STB && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = ST_WB_WAIT;
        end
        wb_hit = (i_wb_ack || i_wb_err) &&
          (state_q == ST_WB_WAIT || !i_wb_stall);
        wb_to = TO_EN && (cnt_q == TLAST);
        if (wb_hit || wb_to) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          bvalid_d = we_q;
          rvalid_d = !we_q;
          resp_d   = (!wb_hit || i_wb_err) ?
            AXI_RESP_SLVERR : AXI_RESP_OKAY;
          if (!we_q) rdata_d = wb_hit ? i_wb_data : '0;
          state_d  = we_q ? ST_B_RESP : ST_R_RESP;
        end
      end
      ST_B_RESP: begin
        if (i_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_R_RESP: begin
        if (i_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any WB cycle at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      resp_q   <= AXI_RESP_OKAY;
      rdata_q  <= '0;
      cnt_q    <= '0;
      lww_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      lww_q    <= lww_d;
    end
  end

  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = sel_q;
  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = resp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rresp  = resp_q;
  assign o_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axilite2wbm.sv
// Self-checking bench for axilite2wbm.
// Directed table, hand sequences and randomized traffic.
`timescale 1ns/1ps
module tb_axilite2wbm;

  localparam int AWID = 28;

  logic clk = 1'b0;
  logic rst;
  logic awvalid, awready, wvalid, wready;
  logic [AWID-1:0] awaddr, araddr;
  logic [31:0] wdata, rdata, wb_wdata, wb_rdata;
  logic [3:0] wstrb, wb_sel;
  logic bvalid, bready, rvalid, rready;
  logic arvalid, arready;
  logic [1:0] bresp, rresp;
  logic wb_cyc, wb_stb, wb_we;
  logic [AWID-3:0] wb_addr;
  logic wb_stall, wb_ack, wb_err;

  always #5 clk = ~clk;

  axilite2wbm #(.C_AXI_ADDR_WIDTH(AWID), .LGTIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_awaddr(awaddr), .i_axi_awprot(3'b010),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .o_axi_bresp(bresp),
    .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .i_axi_araddr(araddr), .i_axi_arprot(3'b101),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
    .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          stall;
    int          ack_at;
    bit          err;
    bit          both;
    bit          nores;
    int          rdly;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_stb;
    int          e_cyc;
    logic [25:0] e_addr;
    logic [3:0]  e_sel;
  } vec_t;

  int tests = 0;
  int fails = 0;
  bit last_wr = 1'b0;

  // Bus monitor: cycle counts, request capture, ready legality.
  int mon_cyc = 0;
  int mon_stb = 0;
  int viol = 0;
  logic [25:0] mon_addr;
  logic [31:0] mon_data;
  logic [3:0]  mon_sel;
  logic        mon_we;
  logic        prev_stb = 1'b0;
  bit          order_q[$];

  always @(negedge clk) begin
    if (wb_cyc) mon_cyc++;
    if (wb_stb) begin
      mon_stb++;
      mon_addr = wb_addr;
      mon_data = wb_wdata;
      mon_sel  = wb_sel;
      mon_we   = wb_we;
    end
    if (wb_stb && !prev_stb) order_q.push_back(wb_we);
    prev_stb = wb_stb;
    if ((wb_cyc || bvalid || rvalid) &&
        (awready || wready || arready))
      viol++;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    bit wr, logic [27:0] a, logic [31:0] d, logic [3:0] s,
    int st, int ak, bit er, bit bo, bit nr, int rd,
    logic [1:0] ers, logic [31:0] erd, int es, int ec,
    logic [25:0] ea, logic [3:0] esl);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.stall = st; v.ack_at = ak; v.err = er; v.both = bo;
    v.nores = nr; v.rdly = rd; v.e_resp = ers;
    v.e_rdata = erd; v.e_stb = es; v.e_cyc = ec;
    v.e_addr = ea; v.e_sel = esl;
    return v;
  endfunction

  // Reference model: expectations from the bridge's rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    r.e_addr  = v.addr[27:2];
    r.e_sel   = v.wr ? v.strb : 4'hf;
    r.e_resp  = (v.err || v.nores) ? 2'b10 : 2'b00;
    r.e_rdata = v.nores ? 32'h0 : v.data;
    r.e_stb   = v.nores ? 1 : v.stall + 1;
    r.e_cyc   = v.nores ? 15 : v.stall + 1 + v.ack_at;
    return r;
  endfunction

  task automatic axi_req(input bit wr, input logic [27:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s);
    int n = 0;
    if (wr) begin
      awvalid = 1'b1; awaddr = a;
      wvalid = 1'b1; wdata = d; wstrb = s;
    end else begin
      arvalid = 1'b1; araddr = a;
    end
    #1;
    while (!(wr ? (awready && wready) : arready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", wr ? (awready && wready) : arready, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  // WB slave: stalls, then acks/errs ack_at cycles after stb is taken.
  task automatic wb_slave(input int stall_n, input int ack_at,
                          input bit err, input bit both,
                          input bit nores,
                          input logic [31:0] rd);
    int n = 0;
    while (!wb_stb && n < 20) begin
      @(negedge clk); n++;
    end
    if (!wb_stb) begin
      chk("wb_stb_seen", wb_stb, 1);
      return;
    end
    if (nores) begin
      wb_stall = 1'b0;
      return;
    end
    for (int k = 0; k < stall_n; k++) begin
      wb_stall = 1'b1;
      @(negedge clk);
    end
    wb_stall = 1'b0;
    for (int k = 0; k < ack_at; k++) @(negedge clk);
    wb_ack = !err || both;
    wb_err = err;
    wb_rdata = rd;
    @(negedge clk);
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_rdata = $urandom;
  endtask

  task automatic resp_phase(input bit wr, input int rdly,
                            output logic [1:0] r,
                            output logic [31:0] d,
                            output bit ok);
    int n = 0;
    while (!(wr ? bvalid : rvalid) && n < 40) begin
      @(negedge clk); n++;
    end
    ok = wr ? bvalid : rvalid;
    chk("resp_valid", ok, 1);
    if (!ok) return;
    r = wr ? bresp : rresp;
    d = rdata;
    for (int k = 0; k < rdly; k++) begin
      // Stray ack outside cyc must not disturb the response.
      wb_ack = 1'b1;
      wb_rdata = $urandom;
      @(negedge clk);
      chk("resp_hold", {wr ? bvalid : rvalid, wr ? bresp : rresp},
          {1'b1, r});
      if (!wr) chk("rdata_hold", rdata, d);
    end
    wb_ack = 1'b0;
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("valid_drop", wr ? bvalid : rvalid, 0);
  endtask

  task automatic run(input vec_t v, input string tag);
    int c0, s0;
    logic [1:0] r;
    logic [31:0] d;
    bit ok;
    c0 = mon_cyc;
    s0 = mon_stb;
    fork
      axi_req(v.wr, v.addr, v.data, v.strb);
      wb_slave(v.stall, v.ack_at, v.err, v.both,
               v.nores, v.data);
    join
    resp_phase(v.wr, v.rdly, r, d, ok);
    last_wr = v.wr;
    if (!ok) return;
    chk({tag, "_addr"}, mon_addr, v.e_addr);
    chk({tag, "_sel"}, mon_sel, v.e_sel);
    chk({tag, "_we"}, mon_we, v.wr);
    if (v.wr) chk({tag, "_wdata"}, mon_data, v.data);
    chk({tag, "_stb_cycles"}, mon_stb - s0, v.e_stb);
    chk({tag, "_cyc_cycles"}, mon_cyc - c0, v.e_cyc);
    chk({tag, "_resp"}, r, v.e_resp);
    if (!v.wr && !(v.err && !v.nores))
      chk({tag, "_rdata"}, d, v.e_rdata);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int idx0;
    bit exp_w;

    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bready = 0; rready = 0;
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_readies", {awready, wready, arready}, 0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = mkv(1, 28'h10, 32'hDEADBEEF, 4'hc, 0, 1, 0, 0, 0, 0,
                 2'b00, 0, 1, 2, 26'h4, 4'hc);
    tbl[1] = mkv(0, 28'h20, 32'h12345678, 4'h0, 3, 2, 0, 0, 0, 1,
                 2'b00, 32'h12345678, 4, 6, 26'h8, 4'hf);
    tbl[2] = mkv(1, 28'h104, 32'h0BADF00D, 4'hf, 1, 1, 1, 0, 0, 2,
                 2'b10, 0, 2, 3, 26'h41, 4'hf);
    tbl[3] = mkv(0, 28'h38, 32'hCAFEF00D, 4'h0, 0, 0, 0, 0, 1, 2,
                 2'b10, 32'h0, 1, 15, 26'he, 4'hf);
    tbl[4] = mkv(0, 28'hFFFFFFF, 32'hA5A55A5A, 4'h0, 2, 0, 0, 0, 0,
                 0, 2'b00, 32'hA5A55A5A, 3, 3, 26'h3FFFFFF, 4'hf);
    tbl[5] = mkv(0, 28'h0, 32'h11112222, 4'h0, 0, 1, 1, 1, 0, 0,
                 2'b10, 0, 1, 2, 26'h0, 4'hf);
    tbl[6] = mkv(1, 28'h200, 32'h55AA33CC, 4'h3, 4, 10, 0, 0, 0, 1,
                 2'b00, 0, 5, 15, 26'h80, 4'h3);
    tbl[7] = mkv(1, 28'hA3, 32'h00000077, 4'h1, 0, 2, 0, 0, 0, 0,
                 2'b00, 0, 1, 3, 26'h28, 4'h1);
    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Lone AW must wait for W; both then handshake together.
    idx0 = mon_stb;
    awvalid = 1'b1;
    awaddr = 28'h40;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("aw_alone_ready", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    chk("aw_alone_no_wb", mon_stb - idx0, 0);
    run(tbl[0], "aw_then_w");

    // Concurrent AW+W and AR: alternate after the last served one.
    idx0 = order_q.size();
    exp_w = !last_wr;
    bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 28'h80;
    wdata = 32'h01020304; wstrb = 4'hf;
    arvalid = 1'b1; araddr = 28'h84;
    for (int k = 0; k < 4; k++)
      wb_slave(0, 1, 0, 0, 0, $urandom);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("arb_count", order_q.size() - idx0, 4);
    for (int k = 0; k < 4; k++) begin
      if (order_q.size() > idx0 + k)
        chk($sformatf("arb_order%0d", k), order_q[idx0 + k],
            exp_w ^ k[0]);
    end
    last_wr = exp_w ^ 1'b1;
    chk("arb_no_pending", {bvalid, rvalid}, 2'b00);

    // Reset while waiting for a WB ack with bready low.
    fork
      axi_req(1, 28'h60, 32'h9999AAAA, 4'hf);
      wb_slave(0, 0, 0, 0, 1, 0);
    join
    @(negedge clk);
    chk("pre_rst_cyc", wb_cyc, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_cyc", wb_cyc, 0);
    chk("async_rst_stb", wb_stb, 0);
    chk("async_rst_bvalid", bvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    last_wr = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_no_resp", {bvalid, rvalid, wb_cyc}, 0);
    run(tbl[1], "post_rst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 28'($urandom);
      v.data   = $urandom;
      v.strb   = 4'($urandom);
      v.stall  = $urandom_range(0, 4);
      v.ack_at = $urandom_range(0, 4);
      v.err    = ($urandom_range(0, 5) == 0);
      v.both   = v.err && ($urandom_range(0, 1) == 1);
      v.nores  = ($urandom_range(0, 7) == 0);
      v.rdly   = $urandom_range(0, 3);
      v = model(v);
      run(v, $sformatf("rnd%0d", i));
    end

    chk("ready_outside_idle", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
